// File: rtl/store_align_buffer.sv
// store_align_buffer: turns SB/SH/SW register data into lane-aligned word
// writes with byte enables and queues them in a small FIFO in front of the
// data memory port. Misaligned stores are dropped and flagged.
module store_align_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        st_ready,
  output logic        st_misalign,
  output logic        buf_empty,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [5:0]  OP_SB = 6'd40;
  localparam logic [5:0]  OP_SH = 6'd41;
  localparam logic [5:0]  OP_SW = 6'd43;

  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [29:0]      r_addr_q [DEPTH];
  logic [31:0]      r_data_q [DEPTH];
  logic [3:0]       r_be_q   [DEPTH];

  logic        w_is_sb;
  logic        w_is_sh;
  logic        w_is_sw;
  logic        w_is_st;
  logic        w_misalign;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_fmt_data;
  logic [3:0]  w_fmt_be;

  assign w_is_sb    = (opcode == OP_SB);
  assign w_is_sh    = (opcode == OP_SH);
  assign w_is_sw    = (opcode == OP_SW);
  assign w_is_st    = st_valid & (w_is_sb | w_is_sh | w_is_sw);
  assign w_misalign = (w_is_sh & addr[0]) | (w_is_sw & (addr[1:0] != 2'b00));
  assign w_accept   = w_is_st & st_ready;
  assign w_push     = w_accept & ~w_misalign;
  assign w_pop      = mem_req & mem_ack;

  // Lane replication and byte-enable generation for the incoming store
  always_comb begin
    w_fmt_data = wdata;
    w_fmt_be   = 4'b0000;
    if (w_is_sb) begin
      w_fmt_data = {4{wdata[7:0]}};
      w_fmt_be   = 4'b0001 << addr[1:0];
    end else if (w_is_sh) begin
      w_fmt_data = {2{wdata[15:0]}};
      w_fmt_be   = addr[1] ? 4'b1100 : 4'b0011;
    end else if (w_is_sw) begin
      w_fmt_data = wdata;
      w_fmt_be   = 4'b1111;
    end
  end

  // Occupancy, pointers and the misalign pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      st_misalign <= 1'b0;
    end else begin
      st_misalign <= w_accept & w_misalign;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between tail and head
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_q[r_wr_ptr] <= addr[31:2];
      r_data_q[r_wr_ptr] <= w_fmt_data;
      r_be_q[r_wr_ptr]   <= w_fmt_be;
    end
  end

  assign st_ready  = (r_count != CNT_W'(DEPTH));
  assign buf_empty = (r_count == '0);
  assign mem_req   = ~buf_empty;

  // Head presentation, forced to zero while empty so stale slots never show
  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    if (mem_req) begin
      mem_addr  = {r_addr_q[r_rd_ptr], 2'b00};
      mem_wdata = r_data_q[r_rd_ptr];
      mem_be    = r_be_q[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations along the sequence.
module tb_store_align_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        st_ready;
  logic        st_misalign;
  logic        buf_empty;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];
  logic [3:0]  q_be   [$];
  logic        exp_mis = 1'b0;

  store_align_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .opcode(opcode), .addr(addr),
    .wdata(wdata), .st_ready(st_ready), .st_misalign(st_misalign),
    .buf_empty(buf_empty), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: size/offset byte-lane view of a store, FIFO as queues
  always @(posedge clk) begin
    int          size;
    int          off;
    bit          is_st;
    bit          mis;
    bit          ready;
    bit          pop;
    logic [31:0] d;
    logic [3:0]  b;
    if (rst) begin
      q_addr.delete(); q_data.delete(); q_be.delete();
      exp_mis = 1'b0;
    end else begin
      size  = (opcode == 6'd40) ? 1 : (opcode == 6'd41) ? 2 : 4;
      is_st = st_valid && (opcode == 6'd40 || opcode == 6'd41 || opcode == 6'd43);
      off   = int'(addr[1:0]);
      mis   = (off % size) != 0;
      ready = q_addr.size() != DEPTH;
      pop   = (q_addr.size() != 0) && mem_ack;
      exp_mis = is_st && ready && mis;
      for (int i = 0; i < 4; i++) begin
        b[i]       = (i >= off) && (i < off + size);
        d[8*i +: 8] = wdata[8*(i % size) +: 8];
      end
      if (pop) begin
        void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_be.pop_front());
      end
      if (is_st && ready && !mis) begin
        q_addr.push_back({addr[31:2], 2'b00}); q_data.push_back(d); q_be.push_back(b);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_req",   32'(mem_req),     32'(q_addr.size() != 0));
      chk("m_empty", 32'(buf_empty),   32'(q_addr.size() == 0));
      chk("m_ready", 32'(st_ready),    32'(q_addr.size() != DEPTH));
      chk("m_mis",   32'(st_misalign), 32'(exp_mis));
      if (q_addr.size() != 0) begin
        chk("m_addr",  mem_addr,      q_addr[0]);
        chk("m_wdata", mem_wdata,     q_data[0]);
        chk("m_be",    32'(mem_be),   32'(q_be[0]));
      end else begin
        chk("m_addr0",  mem_addr,    32'h0);
        chk("m_wdata0", mem_wdata,   32'h0);
        chk("m_be0",    32'(mem_be), 32'h0);
      end
    end
  end

  task automatic step(input logic v, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic ack, input logic r = 1'b0);
    st_valid = v; opcode = op; addr = a; wdata = d; mem_ack = ack; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 6'd0, 32'h0, 32'h0, ack);
  endtask

  initial begin
    step(1'b0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_empty", 32'(buf_empty), 32'd1);
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_mis",   32'(st_misalign), 32'd0);
    chk("rst_addr",  mem_addr, 32'h0);

    // SW word store, latency one, then ack
    step(1'b1, 6'd43, 32'h100, 32'hDEADBEEF, 1'b0);
    chk("sw_req",   32'(mem_req), 32'd1);
    chk("sw_addr",  mem_addr, 32'h100);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_be",    32'(mem_be), 32'hF);
    idle(1'b1);
    chk("sw_empty", 32'(buf_empty), 32'd1);

    // SB lane 3, then SH upper half enqueued in the same cycle as the pop
    step(1'b1, 6'd40, 32'h203, 32'h12345678, 1'b0);
    chk("sb_addr",  mem_addr, 32'h200);
    chk("sb_wdata", mem_wdata, 32'h78787878);
    chk("sb_be",    32'(mem_be), 32'h8);
    step(1'b1, 6'd41, 32'h202, 32'hAAAA5566, 1'b1);
    chk("sh_addr",  mem_addr, 32'h200);
    chk("sh_wdata", mem_wdata, 32'h55665566);
    chk("sh_be",    32'(mem_be), 32'hC);
    idle(1'b1);

    // Misaligned SH and SW are dropped and flagged
    step(1'b1, 6'd41, 32'h101, 32'h1111, 1'b0);
    chk("mis_sh",    32'(st_misalign), 32'd1);
    chk("mis_sh_e",  32'(buf_empty), 32'd1);
    step(1'b1, 6'd43, 32'h102, 32'h2222, 1'b0);
    chk("mis_sw",    32'(st_misalign), 32'd1);
    chk("mis_sw_e",  32'(buf_empty), 32'd1);
    idle(1'b0);
    chk("mis_clr",   32'(st_misalign), 32'd0);

    // Fill with ack held low; fifth store stalls until a pop frees a slot
    for (int k = 0; k < 4; k++)
      step(1'b1, 6'd43, 32'h300 + 32'(4*k), 32'h1000 + 32'(k), 1'b0);
    chk("full_ready", 32'(st_ready), 32'd0);
    step(1'b1, 6'd43, 32'h310, 32'h1004, 1'b0);
    chk("full_hold",  32'(st_ready), 32'd0);
    chk("full_head",  mem_wdata, 32'h1000);
    step(1'b1, 6'd43, 32'h310, 32'h1004, 1'b1);
    chk("pop_head",   mem_wdata, 32'h1001);
    chk("pop_ready",  32'(st_ready), 32'd1);
    step(1'b1, 6'd43, 32'h310, 32'h1004, 1'b0);
    chk("fifth_in",   32'(st_ready), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_data", mem_wdata, 32'h1000 + 32'(k));
      chk("drain_addr", mem_addr, 32'h300 + 32'(4*k));
      idle(1'b1);
    end
    chk("drain_empty", 32'(buf_empty), 32'd1);

    // Count=2 with simultaneous enqueue and pop, then a non-store opcode
    step(1'b1, 6'd43, 32'h400, 32'h2000, 1'b0);
    step(1'b1, 6'd43, 32'h404, 32'h2001, 1'b0);
    step(1'b1, 6'd43, 32'h408, 32'h2002, 1'b1);
    chk("sim_head",  mem_wdata, 32'h2001);
    step(1'b1, 6'd35, 32'h401, 32'h9999, 1'b0);
    chk("lw_head",   mem_wdata, 32'h2001);
    chk("lw_mis",    32'(st_misalign), 32'd0);
    idle(1'b1);
    chk("sim_next",  mem_wdata, 32'h2002);
    idle(1'b1);
    chk("sim_empty", 32'(buf_empty), 32'd1);

    // Reset in the middle of a stall, with a misaligned store presented
    for (int k = 0; k < 3; k++)
      step(1'b1, 6'd43, 32'h500 + 32'(4*k), 32'h3000 + 32'(k), 1'b0);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    step(1'b1, 6'd41, 32'h501, 32'h4444, 1'b0, 1'b1);
    chk("mrst_empty", 32'(buf_empty), 32'd1);
    chk("mrst_req",   32'(mem_req), 32'd0);
    chk("mrst_ready", 32'(st_ready), 32'd1);
    chk("mrst_mis",   32'(st_misalign), 32'd0);
    idle(1'b1);
    chk("post_ack",   32'(buf_empty), 32'd1);
    idle(1'b0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/store_align_buffer.md
Name: store_align_buffer

Overview:
- Store-side counterpart of the immediate/load extenders: narrows 32-bit register store data (SB/SH/SW) into byte-lane-aligned memory writes with byte enables.
- Queues the writes in a small FIFO between the MEM stage and the data memory port.
- Decouples pipeline stores from memory latency with a valid/ready enqueue side and a req/ack memory side.
- Flags misaligned stores.

Parameters:
- DEPTH, 4, number of buffered store entries (power of two, ≥2).
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- st_valid  input  1  MEM stage presents a candidate store this cycle.
- opcode  input  6  instruction opcode: SB=6'd40, SH=6'd41, SW=6'd43; any other value is ignored.
- addr  input  32  byte address of the store.
- wdata  input  32  register rt value; the low byte/half/word is stored.
- st_ready  output  1  buffer can accept a store; the pipeline stalls MEM while st_valid & !st_ready.
- st_misalign  output  1  one-cycle registered pulse: the previous accepted-cycle store was misaligned and dropped.
- buf_empty  output  1  no pending stores; used for fence/flush.
- mem_req  output  1  head entry valid toward memory.
- mem_addr  output  32  head word address, {addr[31:2],2'b00}.
- mem_wdata  output  32  head lane-aligned data.
- mem_be  output  4  head byte enables; bit i enables bits [8i+7:8i].
- mem_ack  input  1  memory accepts head this cycle.

Behaviour:
- Reset (rst=1 at posedge):
  - count=0, pointers=0, st_misalign=0.
  - Hence st_ready=1, buf_empty=1, mem_req=0.
  - mem_addr/mem_wdata/mem_be reset to 0 (the storage array need not be cleared).
  - Reset mid-operation discards all pending entries; no ack is expected afterwards.
- st_ready = (count != DEPTH). It depends on registered count only, never on mem_ack in the same cycle.
- Store detect: is_st = st_valid & (opcode ∈ {40,41,43}). Non-store opcodes are no-ops, with no flag.
- Alignment check:
  - SB: always aligned.
  - SH: misaligned if addr[0]=1.
  - SW: misaligned if addr[1:0]≠0.
- Accept: is_st & st_ready.
  - Aligned store: written at the tail, count+1.
  - Misaligned store: not written; st_misalign=1 next cycle, otherwise 0.
- Lane formatting, computed at enqueue and stored per entry:
  - SB: wdata = {4{wdata[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{wdata[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata unchanged, be = 4'b1111.
- Memory side:
  - mem_req = (count≠0). mem_addr/mem_wdata/mem_be are driven combinationally from the head entry.
  - mem_addr/mem_wdata/mem_be hold stable while mem_req & !mem_ack.
  - Pop on mem_req & mem_ack; mem_ack while empty is ignored.
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
  - When full, a same-cycle pop does not create room: st_ready was already 0.
  - When empty, an enqueued entry appears on mem_req the next cycle (latency 1). There is no bypass.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- buf_empty = (count==0).

Test Plan:
- Reset, then SW addr=0x100 wdata=0xDEADBEEF -> next cycle: mem_req=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_be=1111. Ack -> buf_empty=1.
- SB addr=0x203 wdata=0x12345678 -> mem_addr=0x200, mem_wdata=0x78787878, mem_be=1000. SH addr=0x202 wdata=0xAAAA5566 -> mem_wdata=0x55665566, mem_be=1100.
- SH addr=0x101, then SW addr=0x102 -> neither enqueued, st_misalign pulses one cycle each, buf_empty stays 1.
- Hold mem_ack=0, issue 5 SWs -> first 4 accepted, st_ready=0 on the 5th and it is held. Ack one -> 5th accepted next cycle. Drain returns data in issue order across pointer wrap.
- Count=2, enqueue and ack the same cycle -> count stays 2, head advances. opcode=35 (LW) with st_valid -> no change.
- Fill 3 entries, assert rst for one cycle mid-stall -> buf_empty=1, mem_req=0, st_ready=1, st_misalign=0.
